// File: rtl/reg_lock_tracker_if.sv
// Lock/unlock handshake bundle between the launcher/writeback side and the
// register lock scoreboard.
interface reg_lock_tracker_if #(
    parameter int NUM_REGS = 32
);
    localparam int RW = $clog2(NUM_REGS);

    logic          lock_valid_i;
    logic [RW-1:0] lock_rd_i;
    logic          lock_ready_o;
    logic          unlock_valid_i;
    logic [RW-1:0] unlock_rd_i;

    modport master (
        output lock_valid_i,
        output lock_rd_i,
        output unlock_valid_i,
        output unlock_rd_i,
        input  lock_ready_o
    );

    modport slave (
        input  lock_valid_i,
        input  lock_rd_i,
        input  unlock_valid_i,
        input  unlock_rd_i,
        output lock_ready_o
    );
endinterface

// File: rtl/reg_lock_tracker.sv
// Register scoreboard: counts outstanding writes per register and exposes a
// lock bit per register for the instruction launcher.
module reg_lock_tracker #(
    parameter int NUM_REGS    = 32,
    parameter int MAX_PENDING = 3
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 clear_i,
    reg_lock_tracker_if.slave    bus,
    output logic [NUM_REGS-1:0]  locks_o,
    output logic                 unlock_err_o
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Register 0 is hardwired, so it has no counter.
    logic [NUM_REGS-1:1][CW-1:0] cnt_q;
    logic [NUM_REGS-1:1][CW-1:0] cnt_nxt;
    logic [CW-1:0]               lock_cnt;
    logic [CW-1:0]               unlock_cnt;
    logic                        lock_fire;
    logic                        unlock_fire;
    logic                        same_reg;
    logic                        err_set;
    logic                        inc;
    logic                        dec;
    logic                        err_q;

    always_comb begin
        lock_cnt   = '0;
        unlock_cnt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.lock_rd_i == RW'(r)) begin
                lock_cnt = cnt_q[r];
            end
            if (bus.unlock_rd_i == RW'(r)) begin
                unlock_cnt = cnt_q[r];
            end
        end
    end

    assign bus.lock_ready_o = (bus.lock_rd_i == '0) || (lock_cnt < CNT_MAX);

    assign lock_fire   = bus.lock_valid_i && bus.lock_ready_o && (bus.lock_rd_i != '0);
    assign unlock_fire = bus.unlock_valid_i && (bus.unlock_rd_i != '0);
    assign same_reg    = lock_fire && unlock_fire && (bus.lock_rd_i == bus.unlock_rd_i);
    // A matched lock+unlock on an idle register nets out and is not an error.
    assign err_set     = unlock_fire && (unlock_cnt == '0) && !same_reg;

    always_comb begin
        cnt_nxt = cnt_q;
        inc     = 1'b0;
        dec     = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc = lock_fire && (bus.lock_rd_i == RW'(r));
            dec = unlock_fire && (bus.unlock_rd_i == RW'(r));
            if (inc && !dec) begin
                cnt_nxt[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc && (cnt_q[r] != '0)) begin
                cnt_nxt[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        locks_o = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            locks_o[r] = (cnt_q[r] != '0);
        end
    end

    assign unlock_err_o = err_q;
endmodule
